// File: rtl/div_result_memo_if.sv
// rtl/div_result_memo_if.sv - pipeline and divider signals around the divide result memo
interface div_result_memo_if #(
   parameter int XLEN = 64
);
   logic            StallM;
   logic            FlushE;
   logic            IntDivE;
   logic            DivSignedE;
   logic            W64E;
   logic [XLEN-1:0] ForwardedSrcAE;
   logic [XLEN-1:0] ForwardedSrcBE;
   logic            DivStartE;
   logic            DivDoneM;
   logic [XLEN-1:0] DivQuotM;
   logic [XLEN-1:0] DivRemM;
   logic            DivReqE;
   logic            MemoHitM;
   logic [XLEN-1:0] QuotM;
   logic [XLEN-1:0] RemM;

   modport master (
      output StallM, FlushE, IntDivE, DivSignedE, W64E,
      output ForwardedSrcAE, ForwardedSrcBE,
      output DivStartE, DivDoneM, DivQuotM, DivRemM,
      input  DivReqE, MemoHitM, QuotM, RemM
   );

   modport slave (
      input  StallM, FlushE, IntDivE, DivSignedE, W64E,
      input  ForwardedSrcAE, ForwardedSrcBE,
      input  DivStartE, DivDoneM, DivQuotM, DivRemM,
      output DivReqE, MemoHitM, QuotM, RemM
   );
endinterface

// File: rtl/div_result_memo.sv
// rtl/div_result_memo.sv - one-entry memo of the last completed division
// Serves repeated div/rem operands from the entry and suppresses the divider start on a hit.
module div_result_memo #(
   parameter int XLEN    = 64,
   parameter bit MEMO_EN = 1'b1
) (
   input logic               clk,
   input logic               reset,
   div_result_memo_if.slave  bus
);

   typedef enum logic {
      PEND_IDLE,
      PEND_BUSY
   } pend_state_t;

   pend_state_t     pend_state;
   pend_state_t     pend_next;

   logic            valid;
   logic [XLEN-1:0] tag_a;
   logic [XLEN-1:0] tag_b;
   logic            tag_signed;
   logic            tag_w64;
   logic [XLEN-1:0] memo_quot;
   logic [XLEN-1:0] memo_rem;

   logic [XLEN-1:0] pend_a;
   logic [XLEN-1:0] pend_b;
   logic            pend_signed;
   logic            pend_w64;

   logic            pend;
   logic            hit_e;
   logic            entry_write;
   logic            pend_capture;

   logic            memo_hit_m;
   logic [XLEN-1:0] hit_quot;
   logic [XLEN-1:0] hit_rem;

   assign pend = (pend_state == PEND_BUSY);

   // Raw operand compare; W-type upper bits are not masked, so a mismatch there just misses.
   assign hit_e = MEMO_EN
                & bus.IntDivE
                & valid
                & ~pend
                & (bus.ForwardedSrcAE == tag_a)
                & (bus.ForwardedSrcBE == tag_b)
                & (bus.DivSignedE == tag_signed)
                & (bus.W64E == tag_w64);

   assign bus.DivReqE = bus.IntDivE & ~hit_e;

   always_ff @(posedge clk) begin
      if (reset) begin
         pend_state <= PEND_IDLE;
      end else begin
         pend_state <= pend_next;
      end
   end

   // Completion beats a same-cycle flush: the divider result is already final.
   always_comb begin
      pend_next    = pend_state;
      entry_write  = 1'b0;
      pend_capture = 1'b0;
      case (pend_state)
         PEND_IDLE: begin
            pend_next = PEND_IDLE;
         end
         PEND_BUSY: begin
            if (bus.DivDoneM) begin
               entry_write = 1'b1;
               pend_next   = PEND_IDLE;
            end else if (bus.FlushE) begin
               pend_next = PEND_IDLE;
            end
         end
         default: begin
            pend_next = PEND_IDLE;
         end
      endcase
      if (bus.DivStartE) begin
         pend_capture = 1'b1;
         pend_next    = PEND_BUSY;
      end
   end

   always_ff @(posedge clk) begin
      if (pend_capture) begin
         pend_a      <= bus.ForwardedSrcAE;
         pend_b      <= bus.ForwardedSrcBE;
         pend_signed <= bus.DivSignedE;
         pend_w64    <= bus.W64E;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid <= 1'b0;
      end else if (entry_write) begin
         valid <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (entry_write) begin
         tag_a      <= pend_a;
         tag_b      <= pend_b;
         tag_signed <= pend_signed;
         tag_w64    <= pend_w64;
         memo_quot  <= bus.DivQuotM;
         memo_rem   <= bus.DivRemM;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         memo_hit_m <= 1'b0;
      end else if (!bus.StallM) begin
         memo_hit_m <= hit_e & ~bus.FlushE;
      end
   end

   always_ff @(posedge clk) begin
      if (!bus.StallM) begin
         hit_quot <= memo_quot;
         hit_rem  <= memo_rem;
      end
   end

   assign bus.MemoHitM = memo_hit_m;
   assign bus.QuotM    = memo_hit_m ? hit_quot : bus.DivQuotM;
   assign bus.RemM     = memo_hit_m ? hit_rem  : bus.DivRemM;

endmodule

// File: tb/tb_div_result_memo.sv
// tb/tb_div_result_memo.sv - directed table-driven bench for div_result_memo
module tb_div_result_memo;

   localparam logic [63:0] JUNK = 64'hDEAD_BEEF_0BAD_F00D;

   typedef struct {
      string       name;
      logic [63:0] a;
      logic [63:0] b;
      logic        sgn;
      logic        w64;
      logic        hit;
      logic [63:0] q;
      logic [63:0] r;
   } vec_t;

   logic clk;
   logic reset;
   int   tests;
   int   fails;

   div_result_memo_if #(.XLEN(64)) bus ();
   div_result_memo_if #(.XLEN(64)) bus_off ();

   assign bus_off.StallM         = bus.StallM;
   assign bus_off.FlushE         = bus.FlushE;
   assign bus_off.IntDivE        = bus.IntDivE;
   assign bus_off.DivSignedE     = bus.DivSignedE;
   assign bus_off.W64E           = bus.W64E;
   assign bus_off.ForwardedSrcAE = bus.ForwardedSrcAE;
   assign bus_off.ForwardedSrcBE = bus.ForwardedSrcBE;
   assign bus_off.DivStartE      = bus.DivStartE;
   assign bus_off.DivDoneM       = bus.DivDoneM;
   assign bus_off.DivQuotM       = bus.DivQuotM;
   assign bus_off.DivRemM        = bus.DivRemM;

   div_result_memo #(.XLEN(64), .MEMO_EN(1'b1)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   div_result_memo #(.XLEN(64), .MEMO_EN(1'b0)) dut_off (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_off.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic present(input vec_t v);
      bus.IntDivE        = 1'b1;
      bus.ForwardedSrcAE = v.a;
      bus.ForwardedSrcBE = v.b;
      bus.DivSignedE     = v.sgn;
      bus.W64E           = v.w64;
   endtask

   // Issue one op in E; on a miss play the divider: start, busy cycles, then done with v.q/v.r.
   task automatic do_op(input vec_t v);
      present(v);
      bus.DivDoneM = 1'b0;
      bus.DivQuotM = JUNK;
      bus.DivRemM  = ~JUNK;
      @(negedge clk);
      check({v.name, "/req"}, {63'd0, bus.DivReqE}, {63'd0, ~v.hit});
      check({v.name, "/off_req"}, {63'd0, bus_off.DivReqE}, 64'd1);
      if (!v.hit) begin
         bus.DivStartE = 1'b1;
         next_cycle();
         bus.DivStartE = 1'b0;
         @(negedge clk);
         check({v.name, "/pend_req"}, {63'd0, bus.DivReqE}, 64'd1);
         check({v.name, "/miss_hitm"}, {63'd0, bus.MemoHitM}, 64'd0);
         next_cycle();
         bus.IntDivE = 1'b0;
         next_cycle();
         bus.DivDoneM = 1'b1;
         bus.DivQuotM = v.q;
         bus.DivRemM  = v.r;
         @(negedge clk);
         check({v.name, "/done_quot"}, bus.QuotM, v.q);
         check({v.name, "/done_rem"}, bus.RemM, v.r);
         next_cycle();
         bus.DivDoneM = 1'b0;
         bus.DivQuotM = JUNK;
         bus.DivRemM  = ~JUNK;
      end else begin
         next_cycle();
         bus.IntDivE = 1'b0;
         @(negedge clk);
         check({v.name, "/hitm"}, {63'd0, bus.MemoHitM}, 64'd1);
         check({v.name, "/hit_quot"}, bus.QuotM, v.q);
         check({v.name, "/hit_rem"}, bus.RemM, v.r);
         check({v.name, "/off_hitm"}, {63'd0, bus_off.MemoHitM}, 64'd0);
         next_cycle();
      end
   endtask

   vec_t vecs[8];
   vec_t divw_miss, divw_hit, divs_hit, big_hit, big_miss;

   initial begin
      tests = 0;
      fails = 0;

      vecs[0] = '{"divu_100_7",   64'd100, 64'd7, 1'b0, 1'b0, 1'b0, 64'd14, 64'd2};
      vecs[1] = '{"remu_100_7",   64'd100, 64'd7, 1'b0, 1'b0, 1'b1, 64'd14, 64'd2};
      vecs[2] = '{"div_5_0",      64'd5,   64'd0, 1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5};
      vecs[3] = '{"rem_5_0",      64'd5,   64'd0, 1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5};
      vecs[4] = '{"div_m20_3",    64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 1'b1, 1'b0, 1'b0,
                  64'hFFFF_FFFF_FFFF_FFFA, 64'hFFFF_FFFF_FFFF_FFFE};
      vecs[5] = '{"divu_m20_3",   64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 1'b0, 1'b0, 1'b0,
                  64'h5555_5555_5555_554E, 64'd2};
      vecs[6] = '{"remu_m20_3",   64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 1'b0, 1'b0, 1'b1,
                  64'h5555_5555_5555_554E, 64'd2};
      vecs[7] = '{"div_m20_3_re", 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 1'b1, 1'b0, 1'b0,
                  64'hFFFF_FFFF_FFFF_FFFA, 64'hFFFF_FFFF_FFFF_FFFE};
      divs_hit  = vecs[7];
      divs_hit.name = "div_m20_3_after_flush";
      divs_hit.hit  = 1'b1;
      divw_miss = '{"divw_reissue", 64'h1_0000_0009, 64'd2, 1'b1, 1'b1, 1'b0, 64'd4, 64'd1};
      divw_hit  = divw_miss;
      divw_hit.name = "divw_hit";
      divw_hit.hit  = 1'b1;
      big_hit   = '{"divu_1000_10_hit", 64'd1000, 64'd10, 1'b0, 1'b0, 1'b1, 64'd100, 64'd0};
      big_miss  = big_hit;
      big_miss.name = "divu_1000_10_after_reset";
      big_miss.hit  = 1'b0;

      reset              = 1'b1;
      bus.StallM         = 1'b0;
      bus.FlushE         = 1'b0;
      bus.IntDivE        = 1'b0;
      bus.DivSignedE     = 1'b0;
      bus.W64E           = 1'b0;
      bus.ForwardedSrcAE = '0;
      bus.ForwardedSrcBE = '0;
      bus.DivStartE      = 1'b0;
      bus.DivDoneM       = 1'b0;
      bus.DivQuotM       = 64'h1234;
      bus.DivRemM        = 64'h5678;
      next_cycle();
      next_cycle();
      reset = 1'b0;
      @(negedge clk);
      check("reset/hitm", {63'd0, bus.MemoHitM}, 64'd0);
      check("reset/quot_pass", bus.QuotM, 64'h1234);
      check("reset/rem_pass", bus.RemM, 64'h5678);
      next_cycle();

      for (int i = 0; i < 8; i++) do_op(vecs[i]);

      // divw aborted by a flush: entry must survive, pend must clear
      present(divw_miss);
      @(negedge clk);
      check("divw_flush/req", {63'd0, bus.DivReqE}, 64'd1);
      bus.DivStartE = 1'b1;
      next_cycle();
      bus.DivStartE = 1'b0;
      bus.IntDivE   = 1'b0;
      next_cycle();
      bus.FlushE = 1'b1;
      next_cycle();
      bus.FlushE = 1'b0;
      do_op(divs_hit);
      do_op(divw_miss);
      do_op(divw_hit);

      // completion and flush in the same cycle: the write must still land
      present(big_miss);
      @(negedge clk);
      check("done_flush/req", {63'd0, bus.DivReqE}, 64'd1);
      bus.DivStartE = 1'b1;
      next_cycle();
      bus.DivStartE = 1'b0;
      bus.IntDivE   = 1'b0;
      next_cycle();
      bus.DivDoneM = 1'b1;
      bus.FlushE   = 1'b1;
      bus.DivQuotM = 64'd100;
      bus.DivRemM  = 64'd0;
      @(negedge clk);
      check("done_flush/quot", bus.QuotM, 64'd100);
      next_cycle();
      bus.DivDoneM = 1'b0;
      bus.FlushE   = 1'b0;
      bus.DivQuotM = JUNK;
      bus.DivRemM  = ~JUNK;
      do_op(big_hit);

      // hit followed by a 3-cycle Memory stall with an unrelated op in E
      present(big_hit);
      @(negedge clk);
      check("stall/req", {63'd0, bus.DivReqE}, 64'd0);
      next_cycle();
      bus.StallM         = 1'b1;
      bus.ForwardedSrcAE = 64'd3;
      bus.ForwardedSrcBE = 64'd3;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check($sformatf("stall/hitm%0d", i), {63'd0, bus.MemoHitM}, 64'd1);
         check($sformatf("stall/quot%0d", i), bus.QuotM, 64'd100);
         check($sformatf("stall/rem%0d", i), bus.RemM, 64'd0);
         next_cycle();
      end
      bus.StallM  = 1'b0;
      bus.IntDivE = 1'b0;
      next_cycle();
      @(negedge clk);
      check("stall/release_hitm", {63'd0, bus.MemoHitM}, 64'd0);
      check("stall/release_quot", bus.QuotM, JUNK);
      next_cycle();

      // reset in the middle of a division invalidates the entry
      bus.IntDivE        = 1'b1;
      bus.ForwardedSrcAE = 64'd7;
      bus.ForwardedSrcBE = 64'd2;
      bus.DivSignedE     = 1'b0;
      bus.W64E           = 1'b0;
      bus.DivStartE      = 1'b1;
      next_cycle();
      bus.DivStartE = 1'b0;
      bus.IntDivE   = 1'b0;
      reset         = 1'b1;
      next_cycle();
      reset = 1'b0;
      do_op(big_miss);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
